// File: rtl/cpu8_lsu_pkg.sv
// -----------------------------------------------------------------------------
// cpu8_lsu_pkg
// Shared definitions for the 8-bit CPU load/store unit:
//   - data/address widths and memory depth
//   - request opcode encoding (lsu_op_e)
//   - load/store FSM state encoding (lsu_state_e)
// No ports; imported by lsu_addr_gen and load_store_unit.
// -----------------------------------------------------------------------------
package cpu8_lsu_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 5;
    localparam int MEM_DEPTH = 32;   // must equal 2**ADDR_W

    // Highest legal word address, in both address and data widths.
    localparam logic [ADDR_W-1:0] LAST_ADDR      = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [DATA_W-1:0] LAST_ADDR_DATA = DATA_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_CLR  = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_addr_gen.sv
// -----------------------------------------------------------------------------
// lsu_addr_gen
// Combinational effective-address generator and range check.
//   eff = (base + offset) mod 2**DATA_W   (offset is two's complement, so a
//   plain wrapping add gives the right answer for negative offsets too)
// Ports:
//   i_op        request opcode
//   i_base      unsigned base address
//   i_offset    two's-complement offset
//   o_eff_addr  low ADDR_W bits of the effective address
//   o_fault     address out of range or reserved opcode (never for clear)
// -----------------------------------------------------------------------------
module lsu_addr_gen
    import cpu8_lsu_pkg::*;
(
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_base,
    input  logic [DATA_W-1:0] i_offset,
    output logic [ADDR_W-1:0] o_eff_addr,
    output logic              o_fault
);

    logic [DATA_W-1:0] w_eff;
    lsu_op_e           w_op;

    assign w_op       = lsu_op_e'(i_op);
    assign w_eff      = i_base + i_offset;   // carry out dropped: 8-bit wrap
    assign o_eff_addr = w_eff[ADDR_W-1:0];

    always_comb begin
        // NOTE: default first so every path assigns o_fault and no latch is inferred.
        o_fault = 1'b0;
        case (w_op)
            OP_LOAD,
            OP_STORE: o_fault = (w_eff > LAST_ADDR_DATA);
            OP_CLEAR: o_fault = 1'b0;   // clear ignores base/offset
            OP_RSVD:  o_fault = 1'b1;
            default:  o_fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Sole master of the 32x8 data memory. Accepts one load / store / clear-all
// request at a time, computes base+offset, range-checks it, drives the memory
// and returns read data or a fault on a valid/ready response channel.
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         asynchronous, active-low reset
//   Req_valid     request valid
//   Req_ready     unit can accept a request (IDLE only)
//   Req_op        00 load, 01 store, 10 clear-all, 11 reserved
//   Req_base      unsigned base address
//   Req_offset    two's-complement offset
//   Req_wdata     store data
//   Rsp_valid     response valid
//   Rsp_ready     consumer accepts response
//   Rsp_rdata     load data; 0 for store/clear/fault
//   Rsp_fault     address out of range or reserved op
//   Mem_Address   memory address
//   Mem_Data_in   memory write data
//   Mem_En        memory write enable (memory writes on rising Clk)
//   Mem_Data_out  memory read data (combinational read)
//
// Timing: request taken at edge t0; load/store response visible after t1,
// clear response after t32. All outputs are registered.
// -----------------------------------------------------------------------------
module load_store_unit
    import cpu8_lsu_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic [1:0]        Req_op,
    input  logic [DATA_W-1:0] Req_base,
    input  logic [DATA_W-1:0] Req_offset,
    input  logic [DATA_W-1:0] Req_wdata,
    output logic              Rsp_valid,
    input  logic              Rsp_ready,
    output logic [DATA_W-1:0] Rsp_rdata,
    output logic              Rsp_fault,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Data_in,
    output logic              Mem_En,
    input  logic [DATA_W-1:0] Mem_Data_out
);

    // ------------------------------------------------------------------
    // Effective address and fault for the request currently presented
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_eff_addr;
    logic              w_fault;
    lsu_op_e           w_req_op;

    assign w_req_op = lsu_op_e'(Req_op);

    lsu_addr_gen u_addr_gen (
        .i_op       (Req_op),
        .i_base     (Req_base),
        .i_offset   (Req_offset),
        .o_eff_addr (w_eff_addr),
        .o_fault    (w_fault)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    lsu_state_e        r_state;
    lsu_op_e           r_op;
    logic              r_fault;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_fault;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic              r_mem_en;

    // Req_ready comes out of reset low and rises on the first clock in IDLE,
    // so nothing is accepted on the edge that ends reset.
    // NOTE: the memory array itself has no reset; its contents only change
    // through stores and the CLR sweep, and an aborted sweep leaves it partial.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LOAD;
            r_fault     <= 1'b0;
            r_clr_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_en    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (Req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_op        <= w_req_op;
                        r_fault     <= w_fault;
                        if (w_req_op == OP_CLEAR) begin
                            // First clear word is driven during the first CLR cycle.
                            r_state    <= ST_CLR;
                            r_clr_cnt  <= '0;
                            r_mem_addr <= '0;
                            r_mem_din  <= '0;
                            r_mem_en   <= 1'b1;
                        end else begin
                            // Address is driven even on a fault; with Mem_En low
                            // that is not an access.
                            r_state    <= ST_EXEC;
                            r_mem_addr <= w_eff_addr;
                            if (w_req_op == OP_STORE && !w_fault) begin
                                r_mem_en  <= 1'b1;
                                r_mem_din <= Req_wdata;
                            end
                        end
                    end
                end

                ST_EXEC: begin
                    // A store completes in the memory on this edge; a load
                    // samples the combinational read of the address set at t0.
                    r_mem_en    <= 1'b0;
                    r_mem_din   <= '0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_fault <= r_fault;
                    r_rsp_rdata <= (r_op == OP_LOAD && !r_fault) ? Mem_Data_out : '0;
                    r_state     <= ST_RESP;
                end

                ST_CLR: begin
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_mem_en    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_fault <= 1'b0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_clr_cnt  <= r_clr_cnt + ADDR_W'(1);
                        r_mem_addr <= r_clr_cnt + ADDR_W'(1);
                    end
                end

                ST_RESP: begin
                    // Rsp_valid is high throughout RESP, so Rsp_ready alone
                    // completes the handshake.
                    if (Rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_en    <= 1'b0;
                    r_mem_din   <= '0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign Req_ready   = r_req_ready;
    assign Rsp_valid   = r_rsp_valid;
    assign Rsp_rdata   = r_rsp_rdata;
    assign Rsp_fault   = r_rsp_fault;
    assign Mem_Address = r_mem_addr;
    assign Mem_Data_in = r_mem_din;
    assign Mem_En      = r_mem_en;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the 32x8 data memory and is its only master.
- Accepts one load/store/clear request at a time from the CPU execute stage over a valid/ready handshake.
- Computes the effective address as base + signed offset and range-checks it against the memory depth.
- Drives the memory's address/data/write-enable, then returns read data or a fault over a valid/ready response channel.

Parameters:
DATA_W, 8, data and base/offset width
ADDR_W, 5, memory address width
MEM_DEPTH, 32, number of memory words (must equal 2**ADDR_W)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Req_valid  in  1  request valid
Req_ready  out  1  unit can accept a request
Req_op  in  2  00 load, 01 store, 10 clear-all, 11 reserved
Req_base  in  DATA_W  unsigned base address
Req_offset  in  DATA_W  two's-complement offset
Req_wdata  in  DATA_W  store data
Rsp_valid  out  1  response valid
Rsp_ready  in  1  consumer accepts response
Rsp_rdata  out  DATA_W  load data; 0x00 for store/clear/fault
Rsp_fault  out  1  address out of range or reserved op
Mem_Address  out  ADDR_W  to memory Address
Mem_Data_in  out  DATA_W  to memory Data_in
Mem_En  out  1  to memory En (write enable, writes on rising Clk)
Mem_Data_out  in  DATA_W  from memory Data_out (combinational read)

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low; Reset=0 forces the FSM to IDLE at once.
- Reset values: Req_ready=1 once out of reset; Rsp_valid=0, Rsp_rdata=0, Rsp_fault=0, Mem_Address=0, Mem_Data_in=0, Mem_En=0.
- Effective address: eff = (Req_base + Req_offset) mod 256, as an 8-bit wrapping add.
  - Fault if eff > MEM_DEPTH-1, or if Req_op = 11.
  - Mem_Address = eff[ADDR_W-1:0].
- FSM states: IDLE, EXEC, CLR, RESP.
- IDLE:
  - Req_ready=1.
  - On Req_valid&&Req_ready at edge t0, latch op, address, wdata and fault.
  - Go to CLR if op=10, else to EXEC.
- EXEC (one cycle):
  - Load, no fault: Mem_En=0; capture Mem_Data_out into Rsp_rdata at edge t1.
  - Store, no fault: Mem_En=1, Mem_Data_in=wdata; the memory writes at edge t1. Rsp_rdata=0.
  - Fault: Mem_En=0, no memory access; Rsp_rdata=0, Rsp_fault=1.
  - Go to RESP at t1.
- CLR:
  - 5-bit counter from 0 to 31; Mem_Address=counter, Mem_Data_in=0, Mem_En=1, one word per cycle.
  - After the counter=31 cycle (32 cycles in total), go to RESP.
  - Clear ignores base/offset and never faults.
- RESP:
  - Rsp_valid=1. Rsp_rdata and Rsp_fault are held stable until Rsp_valid&&Rsp_ready.
  - Return to IDLE on that edge.
  - Req_ready=0 in RESP, so there is no back-to-back acceptance. Peak throughput is one load/store per 3 cycles.
- Latency: load/store response is visible after edge t1; clear response after edge t32.
- Mem_En is asserted only in EXEC (store, no fault) and CLR; it is never asserted in IDLE or RESP.
- Mem_Address holds its last value outside EXEC/CLR. Mem_Data_in is 0 outside a store.
- Req_ready=0 in EXEC, CLR and RESP; requests presented then are not taken and must be held by the requester.
- Boundaries:
  - base=0x1F, offset=0x01 gives eff=0x20 and faults.
  - base=0x05, offset=0xFB gives eff=0x00, which is valid.
  - base=0x02, offset=0xFD wraps to eff=0xFF and faults.
- Rsp_ready already high when Rsp_valid rises: the handshake completes on the next edge, with RESP lasting one cycle.
- Reset mid-operation:
  - Abort immediately; a clear in progress leaves memory partially cleared.
  - A write already clocked stays; no response is produced.
  - Mem_En drops asynchronously with Reset.

Decomposition:
- Package cpu8_lsu_pkg holds:
  - op encodings OP_LOAD, OP_STORE, OP_CLEAR, OP_RSVD;
  - state encoding;
  - DATA_W, ADDR_W, MEM_DEPTH constants.
- One sub-module, lsu_addr_gen: combinational 8-bit wrapping add plus range check, producing eff address and fault.
- The FSM, clear counter and response registers stay in load_store_unit.

Test Plan:
- Reset=0 mid-CLR at counter=10 -> all outputs 0 at once, Req_ready=1 after release, Rsp_valid never seen; words 0..9 read back 0x00, word 10 onward keep old values.
- Store base=0x03 off=0x02 wdata=0xA5, then load base=0x05 off=0x00 -> Mem_En high exactly one cycle at address 5; load Rsp_rdata=0xA5, Rsp_fault=0, Rsp_valid after edge t1.
- Load base=0x1F off=0x01 -> Rsp_fault=1, Rsp_rdata=0x00, Mem_En never asserted; repeat with base=0x02 off=0xFD -> fault.
- Load base=0x05 off=0xFB -> address 0, returns that word's content, no fault; Req_op=11 -> fault, no memory access.
- Fill all 32 words with nonzero data, issue clear -> Mem_En high 32 consecutive cycles on addresses 0..31, Rsp_valid after edge t32; every word reads back 0x00.
- Hold Rsp_ready=0 for 5 cycles after a load response -> Rsp_valid/Rsp_rdata stable, Req_ready=0 throughout, a pending request is accepted only after RESP exits.
